backend_redirect_gen: RTL and testbench

Producer side of the BackendRedirect interface that the IF0 PC register consumes. Sits at the commit end of the backend. Watches committed branches and exceptions, holds a mispredict until its MIPS delay slot has committed, then drives a registered redirect/valid/redirectPC with a valid/ready handshake. Issues a one-cycle backend flush request on handshake.

---
 rtl/backend_redirect_gen_pkg.sv | 6 +
 rtl/redirect_ds_timer.sv | 18 +
 rtl/backend_redirect_gen.sv | 138 +++++++++++++
 tb/tb_backend_redirect_gen.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/backend_redirect_gen_pkg.sv
// backend_redirect_gen_pkg: shared types and constants for the backend redirect producer.
package backend_redirect_gen_pkg;
   typedef enum logic [1:0] {IDLE, WAIT_DS, ISSUE} redirect_state_t;
   typedef enum logic {RD_BRANCH, RD_EXC} redirect_kind_t;
   localparam logic [31:0] EXC_VECTOR_PC = 32'hBFC00380;
endpackage

// File: rtl/redirect_ds_timer.sv
// redirect_ds_timer: saturating delay-slot wait counter with clear/enable and terminal flag.
module redirect_ds_timer #(
   parameter int LIMIT = 64,
   parameter int W = $clog2(LIMIT) + 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic term
);
   logic [W-1:0] cnt_q, cnt_d;
   assign term = cnt_q == W'(LIMIT - 1);
   always_comb cnt_d = clr ? '0 : (en && !term) ? cnt_q + 1'b1 : cnt_q;
   always_ff @(posedge clk or negedge rst)
      if (!rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
endmodule

// File: rtl/backend_redirect_gen.sv
// backend_redirect_gen: commit-side BackendRedirect producer with delay-slot hold and flush pulse.
// Optional REDIRECT_PERF_CNT_EN adds per-kind handshake counters.
module backend_redirect_gen
   import backend_redirect_gen_pkg::*;
#(
   parameter int PC_W = 32,
   parameter logic [PC_W-1:0] EXC_VECTOR = PC_W'(EXC_VECTOR_PC),
   parameter int DS_TIMEOUT = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            br_valid,
   input  logic            br_mispredict,
   input  logic [PC_W-1:0] br_target,
   input  logic            ds_same_cycle,
   input  logic            ds_commit,
   input  logic            exc_valid,
   output logic            redirect,
   output logic            valid,
   output logic [PC_W-1:0] redirectPC,
   input  logic            ready,
   output logic            flush_req,
   output logic            ds_timeout_err
`ifdef REDIRECT_PERF_CNT_EN
   ,
   output logic [31:0]     perf_br_redirects,
   output logic [31:0]     perf_exc_redirects
`endif
);
   redirect_state_t state_q, state_d;
   logic [PC_W-1:0] tgt_q, tgt_d, pc_q, pc_d;
   logic valid_q, valid_d, flush_q, flush_d, err_q, err_d;
   logic tmr_clr, tmr_en, tmr_term, timeout;
`ifdef REDIRECT_PERF_CNT_EN
   redirect_kind_t kind_q, kind_d;
   logic [31:0] perf_br_q, perf_br_d, perf_exc_q, perf_exc_d;
`endif

   redirect_ds_timer #(.LIMIT(DS_TIMEOUT)) u_timer (
      .clk (clk),
      .rst (rst),
      .clr (tmr_clr),
      .en  (tmr_en),
      .term(tmr_term)
   );

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q <= IDLE;
         tgt_q   <= '0;
         pc_q    <= '0;
         valid_q <= 1'b0;
         flush_q <= 1'b0;
         err_q   <= 1'b0;
`ifdef REDIRECT_PERF_CNT_EN
         kind_q     <= RD_BRANCH;
         perf_br_q  <= '0;
         perf_exc_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
         flush_q <= flush_d;
         err_q   <= err_d;
`ifdef REDIRECT_PERF_CNT_EN
         kind_q     <= kind_d;
         perf_br_q  <= perf_br_d;
         perf_exc_q <= perf_exc_d;
`endif
      end

   // Exceptions always override a held branch target, in IDLE and in the delay slot.
   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      tmr_clr = 1'b0;
      tmr_en  = 1'b0;
      timeout = 1'b0;
`ifdef REDIRECT_PERF_CNT_EN
      kind_d  = kind_q;
`endif
      case (state_q)
         IDLE:
            if (exc_valid) begin
               tgt_d   = EXC_VECTOR;
               state_d = ISSUE;
`ifdef REDIRECT_PERF_CNT_EN
               kind_d  = RD_EXC;
`endif
            end else if (br_valid && br_mispredict) begin
               tgt_d   = br_target;
               tmr_clr = 1'b1;
               state_d = ds_same_cycle ? ISSUE : WAIT_DS;
`ifdef REDIRECT_PERF_CNT_EN
               kind_d  = RD_BRANCH;
`endif
            end
         WAIT_DS:
            if (exc_valid) begin
               tgt_d   = EXC_VECTOR;
               state_d = ISSUE;
`ifdef REDIRECT_PERF_CNT_EN
               kind_d  = RD_EXC;
`endif
            end else if (ds_commit) state_d = ISSUE;
            else if (tmr_term) begin
               timeout = 1'b1;
               state_d = ISSUE;
            end else tmr_en = 1'b1;
         ISSUE:
            if (ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      valid_d = state_d == ISSUE;
      pc_d    = (state_q != ISSUE && state_d == ISSUE) ? tgt_d : pc_q;
      flush_d = state_q == ISSUE && ready;
      err_d   = err_q | timeout;
`ifdef REDIRECT_PERF_CNT_EN
      perf_br_d  = perf_br_q + 32'((flush_d && kind_q == RD_BRANCH) ? 1 : 0);
      perf_exc_d = perf_exc_q + 32'((flush_d && kind_q == RD_EXC) ? 1 : 0);
`endif
   end

   assign redirect       = valid_q;
   assign valid          = valid_q;
   assign redirectPC     = pc_q;
   assign flush_req      = flush_q;
   assign ds_timeout_err = err_q;
`ifdef REDIRECT_PERF_CNT_EN
   assign perf_br_redirects  = perf_br_q;
   assign perf_exc_redirects = perf_exc_q;
`endif
endmodule

// File: tb/tb_backend_redirect_gen.sv
// tb_backend_redirect_gen: directed plus randomized check of backend_redirect_gen against a cycle model.
module tb_backend_redirect_gen;
   localparam int DS_TIMEOUT = 4;
   localparam logic [31:0] EXC = 32'hBFC00380;

   logic clk = 1'b0, rst = 1'b0;
   logic br_valid = 0, br_mispredict = 0, ds_same_cycle = 0, ds_commit = 0, exc_valid = 0, ready = 0;
   logic [31:0] br_target = '0;
   logic redirect, valid, flush_req, ds_timeout_err;
   logic [31:0] redirectPC;
`ifdef REDIRECT_PERF_CNT_EN
   logic [31:0] perf_br_redirects, perf_exc_redirects;
`endif

   int total = 0, bad = 0;
   bit m_issue, m_exc, m_flush, m_err;
   logic [31:0] m_pc, m_hold, m_nbr, m_nexc;
   int m_wait;

   always #5 clk = ~clk;

   backend_redirect_gen #(.PC_W(32), .EXC_VECTOR(EXC), .DS_TIMEOUT(DS_TIMEOUT)) dut (
      .clk(clk), .rst(rst), .br_valid(br_valid), .br_mispredict(br_mispredict),
      .br_target(br_target), .ds_same_cycle(ds_same_cycle), .ds_commit(ds_commit),
      .exc_valid(exc_valid), .redirect(redirect), .valid(valid), .redirectPC(redirectPC),
      .ready(ready), .flush_req(flush_req), .ds_timeout_err(ds_timeout_err)
`ifdef REDIRECT_PERF_CNT_EN
      , .perf_br_redirects(perf_br_redirects), .perf_exc_redirects(perf_exc_redirects)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_issue = 0; m_exc = 0; m_flush = 0; m_err = 0;
      m_pc = '0; m_hold = '0; m_nbr = '0; m_nexc = '0; m_wait = -1;
   endtask

   task automatic check_all();
      chk("valid", 32'(valid), 32'(m_issue));
      chk("redirect", 32'(redirect), 32'(m_issue));
      if (m_issue) chk("redirectPC", redirectPC, m_pc);
      chk("flush_req", 32'(flush_req), 32'(m_flush));
      chk("ds_timeout_err", 32'(ds_timeout_err), 32'(m_err));
`ifdef REDIRECT_PERF_CNT_EN
      chk("perf_br", perf_br_redirects, m_nbr);
      chk("perf_exc", perf_exc_redirects, m_nexc);
`endif
   endtask

   // One clock: model reacts to the inputs presented this cycle, then DUT is compared.
   task automatic tick();
      bit go = 0;
      m_flush = 0;
      if (m_issue) begin
         if (ready) begin
            m_issue = 0;
            m_flush = 1;
            if (m_exc) m_nexc++; else m_nbr++;
         end
      end else if (m_wait >= 0) begin
         if (exc_valid) begin go = 1; m_exc = 1; m_hold = EXC; end
         else if (ds_commit) go = 1;
         else if (m_wait + 1 == DS_TIMEOUT) begin go = 1; m_err = 1; end
         else m_wait++;
      end else if (exc_valid) begin
         go = 1; m_exc = 1; m_hold = EXC;
      end else if (br_valid && br_mispredict) begin
         m_exc = 0; m_hold = br_target;
         if (ds_same_cycle) go = 1; else m_wait = 0;
      end
      if (go) begin m_issue = 1; m_pc = m_hold; m_wait = -1; end
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic set_in(input bit bv, input bit mp, input logic [31:0] tgt, input bit ds,
                         input bit dc, input bit ex, input bit rd);
      br_valid = bv; br_mispredict = mp; br_target = tgt; ds_same_cycle = ds;
      ds_commit = dc; exc_valid = ex; ready = rd;
   endtask

   task automatic do_reset();
      #2 rst = 0;
      #1;
      model_reset();
      chk("rst_valid", 32'(valid), 0);
      chk("rst_redirect", 32'(redirect), 0);
      chk("rst_pc", redirectPC, 0);
      chk("rst_flush", 32'(flush_req), 0);
      chk("rst_err", 32'(ds_timeout_err), 0);
      @(posedge clk);
      #1;
      rst = 1;
      set_in(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic redirect_once(input bit ex, input logic [31:0] tgt);
      set_in(1, 1, tgt, 1, 0, ex, 1);
      tick();
      set_in(0, 0, 0, 0, 0, 0, 1);
      tick();
   endtask

   initial begin
      model_reset();
      do_reset();
      tick();
      // same-cycle delay slot, immediate ready
      set_in(1, 1, 32'h80000040, 1, 0, 0, 1);
      tick();
      chk("A_valid", 32'(valid), 1);
      chk("A_pc", redirectPC, 32'h80000040);
      set_in(0, 0, 0, 0, 0, 0, 1);
      tick();
      chk("A_flush", 32'(flush_req), 1);
      chk("A_valid_low", 32'(valid), 0);
      tick();
      chk("A_flush_once", 32'(flush_req), 0);
      // delay slot 3 cycles later, ready stalled for 2
      set_in(1, 1, 32'h80000040, 0, 0, 0, 0);
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      chk("B_not_yet", 32'(valid), 0);
      ds_commit = 1;
      tick();
      chk("B_lat", 32'(valid), 1);
      ds_commit = 0;
      tick();
      tick();
      chk("B_stall_pc", redirectPC, 32'h80000040);
      ready = 1;
      tick();
      chk("B_flush", 32'(flush_req), 1);
      ready = 0;
      tick();
      // exception beats a branch, and an exception in the delay slot
      set_in(1, 1, 32'h80000100, 1, 0, 1, 0);
      tick();
      chk("C_exc_pc", redirectPC, EXC);
      set_in(0, 0, 0, 0, 0, 0, 1);
      tick();
      set_in(1, 1, 32'h80000200, 0, 0, 0, 0);
      tick();
      set_in(0, 0, 0, 0, 0, 1, 0);
      tick();
      chk("C_ds_exc_pc", redirectPC, EXC);
      set_in(0, 0, 0, 0, 0, 0, 1);
      tick();
      ready = 0;
      // delay slot never commits
      set_in(1, 1, 32'h80000300, 0, 0, 0, 0);
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0);
      repeat (3) tick();
      chk("D_err_early", 32'(ds_timeout_err), 0);
      tick();
      chk("D_err", 32'(ds_timeout_err), 1);
      chk("D_pc", redirectPC, 32'h80000300);
      ready = 1;
      tick();
      ready = 0;
      tick();
      chk("D_err_sticky", 32'(ds_timeout_err), 1);
      // reset mid-ISSUE
      set_in(1, 1, 32'h80001000, 1, 0, 0, 0);
      tick();
      chk("R_pc_before", redirectPC, 32'h80001000);
      do_reset();
      tick();
      chk("R_idle", 32'(valid), 0);
      // per-kind counters; a correct branch counts nothing
      redirect_once(0, 32'h80000400);
      redirect_once(0, 32'h80000500);
      redirect_once(1, 32'h80000600);
      set_in(1, 0, 32'h80000700, 1, 0, 0, 1);
      tick();
      chk("P_correct_ignored", 32'(valid), 0);
`ifdef REDIRECT_PERF_CNT_EN
      chk("P_br", perf_br_redirects, 2);
      chk("P_exc", perf_exc_redirects, 1);
`endif
      // randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 249) == 0) do_reset();
         set_in($urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1, $urandom,
                $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 2,
                $urandom_range(0, 99) < 8, $urandom_range(0, 1) == 1);
         tick();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
